cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
Parametrised, synthesizable successor to the CPU bench's fixed clock/reset stimulus. It owns the CPU core's reset and holds it for a programmable number of cycles. It then runs the core and detects program halt, defined as the PC looping on itself for a set number of cycles, with a timeout as fallback. On halt it snapshots NUM_PROBES architectural registers (e.g. x31, x3) and compares them against expected values to produce a pass/fail verdict. It sits between the board or bench top level and the CPU core, so the same harness serves both simulation and FPGA bring-up.

Parameters:
XLEN, 32, width of the PC and each probe register
NUM_PROBES, 2, number of observed registers (1..8)
RESET_CYCLES, 10, cycles cpu_reset_o is held after reset_i deasserts or after restart (>=1)
HALT_STABLE, 4, consecutive cycles with an unchanged PC that constitute a halt (>=2)
TIMEOUT_CYCLES, 1000, maximum RUN cycles before the timeout verdict (>=1)
CNT_W, 32, width of the cycle counter

Ports:
clk_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
restart_i  in  1  single-cycle pulse; valid in DONE or TIMEOUT only; re-enters RESET_HOLD
pc_i  in  XLEN  CPU program counter
probe_i  in  NUM_PROBES*XLEN  observed registers; probe k occupies bits [k*XLEN +: XLEN]
expect_i  in  NUM_PROBES*XLEN  expected probe values, same packing
expect_mask_i  in  NUM_PROBES  1 = compare probe k; 0 = ignore it
cpu_reset_o  out  1  reset to the CPU core, active-high
running_o  out  1  high while in RUN
done_o  out  1  high in DONE (halt detected)
timeout_o  out  1  high in TIMEOUT
pass_o  out  1  valid only when done_o=1: all masked probes matched
cycle_count_o  out  CNT_W  RUN cycles elapsed; frozen on leaving RUN
halt_pc_o  out  XLEN  PC captured at halt or timeout
snapshot_o  out  NUM_PROBES*XLEN  probes captured at halt or timeout

Behaviour:
- Reset (reset_i=1, asynchronous) forces:
  - state RESET_HOLD, hold counter 0;
  - cpu_reset_o=1; running_o, done_o, timeout_o, pass_o all 0;
  - cycle_count_o, halt_pc_o, snapshot_o all 0.
- Reset asserted mid-RUN aborts immediately; cpu_reset_o is high in the same cycle.
- States: RESET_HOLD, RUN, DONE, TIMEOUT.
- RESET_HOLD:
  - cpu_reset_o=1; the hold counter increments each cycle.
  - When the counter reaches RESET_CYCLES-1, go to RUN. This gives exactly RESET_CYCLES clock edges with cpu_reset_o=1 after reset_i falls.
  - On entering RUN, clear the stable counter and cycle_count_o.
- RUN:
  - cpu_reset_o=0, running_o=1. cycle_count_o increments every cycle (saturating at all-ones).
  - prev_pc is registered each cycle.
  - Stable counter:
    - If pc_i == prev_pc, stable counter increments (saturating at HALT_STABLE).
    - Otherwise it resets to 0.
    - The first RUN cycle never counts as stable, because prev_pc is invalid.
  - Halt: stable counter reaches HALT_STABLE-1 while pc_i == prev_pc. That is HALT_STABLE consecutive samples of the same PC. Transition to DONE.
  - Timeout: cycle_count_o == TIMEOUT_CYCLES-1 and no halt this cycle. Transition to TIMEOUT.
  - Halt and timeout in the same cycle: halt wins (DONE).
  - On either exit, at the transition edge:
    - halt_pc_o <= pc_i and snapshot_o <= probe_i.
    - pass_o <= AND over k of (!expect_mask_i[k] | probe_i[k] == expect_i[k]).
    - expect_i and expect_mask_i are sampled at that same edge.
- DONE: done_o=1; pass_o holds its value; cpu_reset_o=0, so the core keeps spinning on its self-loop.
- TIMEOUT:
  - timeout_o=1, pass_o=0; cpu_reset_o=1 to halt a runaway core.
  - Snapshot is still captured, for debug.
- restart_i:
  - In DONE or TIMEOUT: next state RESET_HOLD; verdict outputs clear; snapshot and halt_pc hold until the next capture.
  - Ignored in RESET_HOLD and RUN.
- Outputs are registered or derived from state only. No combinational path from any input to any output.
- An all-zero expect_mask_i gives pass_o=1 on any halt (vacuous pass).

Test Plan:
1. Reset window: reset_i=1 for 10 cycles, then 0 -> cpu_reset_o stays 1 for exactly 10 more rising edges, then 0; running_o rises on the same edge.
2. Normal halt: PC steps 0,4,8,...,0x40 then holds 0x40; probes x31=0x1, x3=0x5; expect the same values, mask 2'b11 -> done_o=1 after the 4th consecutive 0x40 sample; pass_o=1; halt_pc_o=0x40.
3. Mismatch and mask: same run with expect x3=0x6. Mask 2'b11 -> pass_o=0. Mask 2'b01 (x31 only) -> pass_o=1.
4. Timeout: TIMEOUT_CYCLES=50, PC increments forever -> timeout_o=1 after 50 RUN cycles; cycle_count_o=49; cpu_reset_o=1; pass_o=0.
5. Near-halt and tie: PC repeats 3 times, then changes -> no halt. Halt on exactly the timeout cycle -> done_o=1, timeout_o=0.
6. Mid-run reset and restart: assert reset_i mid-RUN -> all outputs return to reset values asynchronously. Pulse restart_i in DONE -> RESET_HOLD, with a RESET_CYCLES reset window again. Pulse restart_i in RUN -> ignored.

Source files
------------

// File: rtl/cpu_run_controller.sv
// ============================================================================
// cpu_run_controller
// ----------------------------------------------------------------------------
// Sits between the board or bench top level and a CPU core. It does four jobs:
//   1. Holds the core in reset for RESET_CYCLES clock edges after reset_i
//      falls, or after a restart.
//   2. Runs the core and counts RUN cycles.
//   3. Detects program halt. A halt is the PC sitting on the same value for
//      HALT_STABLE consecutive samples. A timeout after TIMEOUT_CYCLES RUN
//      cycles is the fallback.
//   4. On halt or timeout, snapshots the PC and NUM_PROBES architectural
//      registers. It then compares the masked probes against expected values
//      to give a pass/fail verdict.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset of the controller
//   restart_i      one-cycle pulse; honoured only in DONE or TIMEOUT
//   pc_i           core program counter
//   probe_i        observed registers, probe k at [k*XLEN +: XLEN]
//   expect_i       expected probe values, same packing as probe_i
//   expect_mask_i  1 = compare probe k, 0 = ignore it
//   cpu_reset_o    active-high reset to the core
//   running_o      high while in RUN
//   done_o         high in DONE (halt detected)
//   timeout_o      high in TIMEOUT
//   pass_o         verdict; meaningful only while done_o=1
//   cycle_count_o  RUN cycles elapsed; frozen once RUN is left
//   halt_pc_o      PC captured at halt or timeout
//   snapshot_o     probes captured at halt or timeout
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// ============================================================================
module cpu_run_controller #(
    parameter int XLEN           = 32,
    parameter int NUM_PROBES     = 2,
    parameter int RESET_CYCLES   = 10,
    parameter int HALT_STABLE    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       restart_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [NUM_PROBES*XLEN-1:0] probe_i,
    input  logic [NUM_PROBES*XLEN-1:0] expect_i,
    input  logic [NUM_PROBES-1:0]      expect_mask_i,
    output logic                       cpu_reset_o,
    output logic                       running_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic                       pass_o,
    output logic [CNT_W-1:0]           cycle_count_o,
    output logic [XLEN-1:0]            halt_pc_o,
    output logic [NUM_PROBES*XLEN-1:0] snapshot_o
);

    // ------------------------------------------------------------------------
    // Derived widths and compare constants
    // ------------------------------------------------------------------------
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STAB_W = $clog2(HALT_STABLE + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX      = STAB_W'(HALT_STABLE);
    // stable_cnt counts repeats after the first sample of a PC value. A halt
    // happens when this sample would take it to HALT_STABLE-1. That means
    // the stored value before this sample is HALT_STABLE-2.
    localparam logic [STAB_W-1:0] STAB_PRE_HALT = STAB_W'(HALT_STABLE - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_DONE       = 2'd2,
        ST_TIMEOUT    = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                      state_q,      state_d;
    logic [HOLD_W-1:0]           hold_cnt_q,   hold_cnt_d;
    logic [STAB_W-1:0]           stable_cnt_q, stable_cnt_d;
    logic [XLEN-1:0]             prev_pc_q,    prev_pc_d;
    logic                        prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0]            cycle_cnt_q,  cycle_cnt_d;
    logic [XLEN-1:0]             halt_pc_q,    halt_pc_d;
    logic [NUM_PROBES*XLEN-1:0]  snapshot_q,   snapshot_d;
    logic                        pass_q,       pass_d;
    logic                        cpu_reset_q,  cpu_reset_d;
    logic                        running_q,    running_d;
    logic                        done_q,       done_d;
    logic                        timeout_q,    timeout_d;

    // ------------------------------------------------------------------------
    // Probe comparison: one match bit per probe. A masked-off probe always
    // counts as matching, so an all-zero mask gives a vacuous pass.
    // ------------------------------------------------------------------------
    logic [NUM_PROBES-1:0] probe_ok;
    logic                  all_match;

    generate
        for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_probe_cmp
            assign probe_ok[gi] = ~expect_mask_i[gi] |
                (probe_i[gi*XLEN +: XLEN] == expect_i[gi*XLEN +: XLEN]);
        end
    endgenerate

    assign all_match = &probe_ok;

    // ------------------------------------------------------------------------
    // Halt and timeout detection
    // ------------------------------------------------------------------------
    logic pc_same;
    logic halt_hit;
    logic timeout_hit;

    // prev_valid_q is low on the first RUN cycle. That stops a stale PC from
    // the previous run counting as a repeat.
    assign pc_same     = prev_valid_q && (pc_i == prev_pc_q);
    assign halt_hit    = pc_same && (stable_cnt_q == STAB_PRE_HALT);
    assign timeout_hit = (cycle_cnt_q == CNT_LAST);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stable_cnt_d = stable_cnt_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        cycle_cnt_d  = cycle_cnt_q;
        halt_pc_d    = halt_pc_q;
        snapshot_d   = snapshot_q;
        pass_d       = pass_q;

        unique case (state_q)
            ST_RESET_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    hold_cnt_d   = '0;
                    stable_cnt_d = '0;
                    prev_valid_d = 1'b0;
                    cycle_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                prev_pc_d    = pc_i;
                prev_valid_d = 1'b1;

                if (pc_same) begin
                    stable_cnt_d = (stable_cnt_q == STAB_MAX) ? stable_cnt_q
                                                              : stable_cnt_q + 1'b1;
                end else begin
                    stable_cnt_d = '0;
                end

                // A halt takes priority over a timeout in the same cycle.
                // cycle_cnt does not advance on the exit edge. This leaves
                // it at the index of the final RUN cycle.
                if (halt_hit) begin
                    state_d    = ST_DONE;
                    halt_pc_d  = pc_i;
                    snapshot_d = probe_i;
                    pass_d     = all_match;
                end else if (timeout_hit) begin
                    state_d    = ST_TIMEOUT;
                    halt_pc_d  = pc_i;
                    snapshot_d = probe_i;
                    pass_d     = 1'b0;
                end else if (cycle_cnt_q != {CNT_W{1'b1}}) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end

            ST_DONE, ST_TIMEOUT: begin
                // The verdict clears. halt_pc and snapshot keep their values
                // so they can still be read until the next capture.
                if (restart_i) begin
                    state_d    = ST_RESET_HOLD;
                    hold_cnt_d = '0;
                    pass_d     = 1'b0;
                end
            end

            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase

        // Outputs are computed from the next state, so they change on the
        // same edge as the state register and come directly from flops.
        // The core is also held in reset during TIMEOUT, to stop a runaway
        // program.
        cpu_reset_d = (state_d == ST_RESET_HOLD) || (state_d == ST_TIMEOUT);
        running_d   = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        timeout_d   = (state_d == ST_TIMEOUT);
    end

    // ------------------------------------------------------------------------
    // Registers. The asynchronous reset puts the core into reset at once,
    // even in the middle of a run.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RESET_HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            cycle_cnt_q  <= '0;
            halt_pc_q    <= '0;
            snapshot_q   <= '0;
            pass_q       <= 1'b0;
            cpu_reset_q  <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            cycle_cnt_q  <= cycle_cnt_d;
            halt_pc_q    <= halt_pc_d;
            snapshot_q   <= snapshot_d;
            pass_q       <= pass_d;
            cpu_reset_q  <= cpu_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign cpu_reset_o   = cpu_reset_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign pass_o        = pass_q;
    assign cycle_count_o = cycle_cnt_q;
    assign halt_pc_o     = halt_pc_q;
    assign snapshot_o    = snapshot_q;

endmodule
